scc_exec_datapath: RTL and testbench



---
 rtl/scc_exec_datapath.sv | 63 ++++++
 tb/tb_scc_exec_datapath.sv | 134 +++++++++++++
 2 files changed

// File: rtl/scc_exec_datapath.sv
// scc_exec_datapath: single-cycle decoder + 8x32 register file + ALU for the SCC core
// Ports: clk, rst_n (sync active-low); instruction word in; dbg_addr/dbg_data async debug read;
//        write_enable/write_addr/write_data expose the register write applied at the next edge.
module scc_exec_datapath #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instruction,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              write_enable,
  output logic [2:0]        write_addr,
  output logic [DATA_W-1:0] write_data
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              valid, ir_op, cls;
  logic [2:0]        op, rd, rn, rm, rd1_addr;
  logic [15:0]       imm;
  logic [DATA_W-1:0] op1, op2, alu_res, mv_res;
  assign valid = ~instruction[31];
  assign ir_op = instruction[30];
  assign cls   = instruction[29];
  assign op    = instruction[27:25];
  assign rd    = instruction[24:22];
  assign rn    = instruction[21:19];
  assign rm    = instruction[18:16];
  assign imm   = instruction[15:0];
  // MOVT needs the old Rd, so read port 1 follows Rd in the data-move class
  assign rd1_addr = cls ? rn : rd;
  assign op1 = regs_q[rd1_addr];
  assign op2 = ir_op ? regs_q[rm] : {16'h0, imm};
  always_comb begin
    alu_res = '0;
    case (op)
      3'b001:  alu_res = op1 + op2;
      3'b010:  alu_res = op1 - op2;
      3'b011:  alu_res = op1 & op2;
      3'b100:  alu_res = op1 | op2;
      3'b101:  alu_res = op1 ^ op2;
      3'b110:  alu_res = ~op1;
      default: alu_res = '0;
    endcase
  end
  always_comb begin
    mv_res = op[1] ? (op[0] ? '1 : '0) : (op[0] ? {imm, op1[15:0]} : {16'h0, imm});
  end
  assign write_enable = valid & (cls ? (op != 3'b000 && op != 3'b111) : ~op[2]);
  assign write_addr   = rd;
  // every NOP flavour drives the ALU result so write_data stays deterministic
  assign write_data   = (valid & ~cls & ~op[2]) ? mv_res : alu_res;
  assign dbg_data     = regs_q[dbg_addr];
  always_comb begin
    regs_d = regs_q;
    if (write_enable) regs_d[rd] = write_data;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end
endmodule

// File: tb/tb_scc_exec_datapath.sv
// tb_scc_exec_datapath: scoreboard bench driving directed instructions into scc_exec_datapath
module tb_scc_exec_datapath;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = 32'h8000_0000;
  logic [2:0]  dbg_addr = 3'd0;
  logic [31:0] dbg_data, write_data;
  logic        write_enable;
  logic [2:0]  write_addr;

  typedef struct {
    int          idx;
    logic [2:0]  addr;
    logic        we_chk;
    logic        we;
    logic [31:0] data;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int errors = 0;
  int n_items = 0;

  scc_exec_datapath dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [31:0] ins, input logic [2:0] da, input logic we_chk,
                      input logic we, input logic [31:0] d, input logic rst = 1'b1);
    item_t it;
    @(negedge clk);
    instruction = ins;
    dbg_addr = da;
    rst_n = rst;
    it.idx = n_items;
    it.addr = da;
    it.we_chk = we_chk;
    it.we = we;
    it.data = d;
    sb.push_back(it);
    n_items++;
  endtask

  task automatic wr(input logic [31:0] ins, input logic [2:0] rd, input logic [31:0] d);
    step(ins, rd, 1'b1, 1'b1, d);
  endtask

  task automatic nop_read(input logic [31:0] ins, input logic [2:0] r, input logic [31:0] d);
    step(ins, r, 1'b1, 1'b0, d);
  endtask

  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        it = sb.pop_front();
        checks++;
        if (dbg_data !== it.data) begin
          errors++;
          $display("FAIL step%0d reg R%0d data: got %h expected %h", it.idx, it.addr, dbg_data, it.data);
        end
        if (it.we_chk) begin
          checks++;
          if (write_enable !== it.we) begin
            errors++;
            $display("FAIL step%0d write_enable: got %b expected %b", it.idx, write_enable, it.we);
          end
          if (it.we) begin
            checks++;
            if (write_addr !== it.addr) begin
              errors++;
              $display("FAIL step%0d write_addr: got %0d expected %0d", it.idx, write_addr, it.addr);
            end
          end
        end
      end
    end
  end

  initial begin
    int budget;
    repeat (2) @(negedge clk);
    for (int r = 0; r < 8; r++) nop_read(32'h8000_0000, 3'(r), 32'h0);
    wr(32'h0000_FFFF, 3'd0, 32'h0000_FFFF);
    wr(32'h0200_EEEE, 3'd0, 32'hEEEE_FFFF);
    wr(32'h0640_0000, 3'd1, 32'hFFFF_FFFF);
    for (int r = 0; r < 8; r++) wr(32'h0400_0000 + 32'(r) * 32'h0040_0000, 3'(r), 32'h0);
    nop_read(32'h8000_0000, 3'd0, 32'h0);
    nop_read(32'h8000_0000, 3'd1, 32'h0);
    wr(32'h0040_0001, 3'd1, 32'h1);
    wr(32'h2200_0001, 3'd0, 32'h1);
    wr(32'h6201_0000, 3'd0, 32'h2);
    wr(32'h2400_0001, 3'd0, 32'h1);
    wr(32'h6400_0000, 3'd0, 32'h0);
    wr(32'h2400_0001, 3'd0, 32'hFFFF_FFFF);
    wr(32'h0000_000F, 3'd0, 32'hF);
    wr(32'h0040_0002, 3'd1, 32'h2);
    wr(32'h6601_0000, 3'd0, 32'h2);
    wr(32'h2800_000F, 3'd0, 32'hF);
    wr(32'h2840_0010, 3'd1, 32'h1F);
    wr(32'h6841_0000, 3'd1, 32'h1F);
    wr(32'h6A01_0000, 3'd0, 32'h10);
    wr(32'h2A00_000F, 3'd0, 32'h1F);
    wr(32'h6C00_0000, 3'd0, 32'hFFFF_FFE0);
    wr(32'h00C0_0005, 3'd3, 32'h5);
    wr(32'h0080_1234, 3'd2, 32'h1234);
    step(32'h06C0_0000, 3'd3, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int r = 0; r < 8; r++) nop_read(32'h8000_0000, 3'(r), 32'h0);
    wr(32'h0080_1234, 3'd2, 32'h1234);
    nop_read(32'h8000_0000, 3'd2, 32'h1234);
    nop_read(32'h2E00_0000, 3'd0, 32'h0);
    nop_read(32'h2080_0000, 3'd2, 32'h1234);
    nop_read(32'h08C0_0007, 3'd3, 32'h0);
    nop_read(32'h8080_FFFF, 3'd2, 32'h1234);
    budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d items left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
